// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel programmable clock-enable / divided-clock generator.
//
// Every channel runs a counter over [0, div-1] and produces a registered square wave
// (div_out), a registered first-cycle-of-period strobe (div_stb) and a lock flag that
// rises once LOCK_PERIODS strobes have been produced since the last apply or reset.
// New period/duty/phase values pass through a single pending slot and are applied to
// the target channel only at its period boundary, so no runt pulses are produced.
//
// Optional feature (macro DIVCLK_SYNC_EN): adds input port sync, which realigns every
// channel with div>=2 to its stored phase on the edge where sync is high.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   nrst       synchronous reset, active-low
//   sync       (DIVCLK_SYNC_EN only) realign all running channels to their phase
//   cfg_valid  config request valid
//   cfg_ready  config slot free; transfer on cfg_valid && cfg_ready
//   cfg_ch     target channel; out-of-range values are accepted and discarded
//   cfg_div    period in clk cycles; 0 disables the channel
//   cfg_duty   high cycles; 0 selects div>>1, values >= div clamp to div-1
//   cfg_phase  counter value loaded on apply (0 if not below the new div)
//   div_out    per-channel divided square wave
//   div_stb    per-channel one-cycle pulse on the first cycle of each period
//   lock       per-channel output-stable flag
module clk_div_gen #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned DIV_WIDTH    = 8,
    parameter int unsigned DEFAULT_DIV  = 4,
    parameter int unsigned LOCK_PERIODS = 2,
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 nrst,
`ifdef DIVCLK_SYNC_EN
    input  logic                 sync,
`endif
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic [DIV_WIDTH-1:0] cfg_duty,
    input  logic [DIV_WIDTH-1:0] cfg_phase,
    output logic [CHANNELS-1:0]  div_out,
    output logic [CHANNELS-1:0]  div_stb,
    output logic [CHANNELS-1:0]  lock
);

    typedef logic [DIV_WIDTH-1:0] word_t;

    localparam word_t       One        = word_t'(1);
    localparam word_t       Two        = word_t'(2);
    localparam word_t       DefDiv     = word_t'(DEFAULT_DIV);
    localparam int unsigned LK_W       = $clog2(LOCK_PERIODS + 1);
    localparam logic [LK_W-1:0] LockTarget = LK_W'(LOCK_PERIODS);
    localparam int unsigned CH_SPAN    = 1 << CH_W;

    function automatic word_t duty_eff(input word_t per, input word_t hi);
        if (hi == '0) begin
            return per >> 1;
        end else if (hi >= per) begin
            return per - One;
        end
        return hi;
    endfunction

    word_t           div_q   [CHANNELS];
    word_t           div_d   [CHANNELS];
    word_t           duty_q  [CHANNELS];
    word_t           duty_d  [CHANNELS];
    word_t           cnt_q   [CHANNELS];
    word_t           cnt_d   [CHANNELS];
    logic [LK_W-1:0] nper_q  [CHANNELS];
    logic [LK_W-1:0] nper_d  [CHANNELS];
`ifdef DIVCLK_SYNC_EN
    word_t           phase_q [CHANNELS];
    word_t           phase_d [CHANNELS];
`endif

    logic [CHANNELS-1:0] out_q, out_d, stb_q, stb_d, lock_q, lock_d, apply;
    logic [CH_SPAN-1:0]  ch_valid;

    logic            pend_q, pend_d;
    logic [CH_W-1:0] pend_ch_q, pend_ch_d;
    word_t           pend_div_q, pend_div_d;
    word_t           pend_duty_q, pend_duty_d;
    word_t           pend_phase_q, pend_phase_d;

    assign cfg_ready = ~pend_q;
    assign div_out   = out_q;
    assign div_stb   = stb_q;
    assign lock      = lock_q;

    // Encodable channel numbers at or above CHANNELS are discarded on accept.
    always_comb begin
        for (int c = 0; c < int'(CH_SPAN); c++) begin
            ch_valid[c] = (c < int'(CHANNELS));
        end
    end

    always_comb begin
        logic [LK_W-1:0] nper_base;
        nper_base    = '0;
        div_d        = div_q;
        duty_d       = duty_q;
        cnt_d        = cnt_q;
        nper_d       = nper_q;
`ifdef DIVCLK_SYNC_EN
        phase_d      = phase_q;
`endif
        out_d        = '0;
        stb_d        = '0;
        lock_d       = '0;
        apply        = '0;
        pend_d       = pend_q;
        pend_ch_d    = pend_ch_q;
        pend_div_d   = pend_div_q;
        pend_duty_d  = pend_duty_q;
        pend_phase_d = pend_phase_q;

        for (int i = 0; i < int'(CHANNELS); i++) begin
            // Boundary: the counter is about to wrap, or the channel has no period.
            apply[i] = pend_q && (pend_ch_q == CH_W'(i)) &&
                       ((div_q[i] <= One) || (cnt_q[i] == div_q[i] - One));

            if (apply[i]) begin
                div_d[i]  = pend_div_q;
                duty_d[i] = pend_duty_q;
                cnt_d[i]  = (pend_phase_q < pend_div_q) ? pend_phase_q : '0;
`ifdef DIVCLK_SYNC_EN
                phase_d[i] = pend_phase_q;
            end else if (sync && (div_q[i] >= Two)) begin
                cnt_d[i] = (phase_q[i] < div_q[i]) ? phase_q[i] : '0;
`endif
            end else if (div_q[i] >= Two) begin
                cnt_d[i] = (cnt_q[i] >= div_q[i] - One) ? '0 : cnt_q[i] + One;
            end else begin
                cnt_d[i] = '0;
            end

            if (div_d[i] == '0) begin
                out_d[i] = 1'b0;
                stb_d[i] = 1'b0;
            end else if (div_d[i] == One) begin
                out_d[i] = 1'b1;
                stb_d[i] = 1'b1;
            end else begin
                out_d[i] = (cnt_d[i] < duty_eff(div_d[i], duty_d[i]));
                stb_d[i] = (cnt_d[i] == '0);
            end

            // Strobe count restarts on apply; a strobe on the apply edge itself counts.
            nper_base = apply[i] ? '0 : nper_q[i];
            nper_d[i] = (stb_d[i] && (nper_base != LockTarget)) ? nper_base + LK_W'(1)
                                                                  : nper_base;
            lock_d[i] = (lock_q[i] && !apply[i]) || (nper_d[i] == LockTarget);
        end

        if (|apply) begin
            pend_d = 1'b0;
        end
        if (cfg_valid && cfg_ready && ch_valid[cfg_ch]) begin
            pend_d       = 1'b1;
            pend_ch_d    = cfg_ch;
            pend_div_d   = cfg_div;
            pend_duty_d  = cfg_duty;
            pend_phase_d = cfg_phase;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                div_q[i]   <= DefDiv;
                duty_q[i]  <= DefDiv >> 1;
                cnt_q[i]   <= DefDiv - One;
                nper_q[i]  <= '0;
`ifdef DIVCLK_SYNC_EN
                phase_q[i] <= '0;
`endif
            end
            out_q        <= '0;
            stb_q        <= '0;
            lock_q       <= '0;
            pend_q       <= 1'b0;
            pend_ch_q    <= '0;
            pend_div_q   <= '0;
            pend_duty_q  <= '0;
            pend_phase_q <= '0;
        end else begin
            div_q        <= div_d;
            duty_q       <= duty_d;
            cnt_q        <= cnt_d;
            nper_q       <= nper_d;
`ifdef DIVCLK_SYNC_EN
            phase_q      <= phase_d;
`endif
            out_q        <= out_d;
            stb_q        <= stb_d;
            lock_q       <= lock_d;
            pend_q       <= pend_d;
            pend_ch_q    <= pend_ch_d;
            pend_div_q   <= pend_div_d;
            pend_duty_q  <= pend_duty_d;
            pend_phase_q <= pend_phase_d;
        end
    end

endmodule
